// File: rtl/azadi_wb_ctrl.sv
// Wishbone control/status slave: UART divisor, sequenced SoC reset, prog strap
// selection and a prog-pad rising-edge interrupt.
module azadi_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          RST_CYCLES = 16,
    parameter logic [15:0] CPB_RESET  = 16'd868
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        prog_pad_i,
    output logic [15:0] clks_per_bit_o,
    output logic        soc_rst_no,
    output logic        prog_o,
    output logic        irq_o
);
    localparam int CW = $clog2(RST_CYCLES + 1);

    typedef enum logic {HOLD, RUN} rst_state_e;

    logic          rst_req, prog_sel, prog_val, irq_en;
    logic [31:0]   scratch;
    logic          prog_edge;
    logic          prog_meta, prog_sync, prog_sync_q;
    rst_state_e    state;
    logic [CW-1:0] count;

    logic          hit, wr;
    logic [1:0]    reg_sel;
    logic [31:0]   rdata;
    logic          edge_set, edge_clr;
    logic          unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    // ack is fed back so a held strobe cannot re-hit while its ack is out
    assign hit     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
    assign wr      = hit & wbs_we_i;
    assign reg_sel = wbs_adr_i[3:2];

    assign edge_set = prog_sync & ~prog_sync_q;
    assign edge_clr = wr && reg_sel == 2'd2 && wbs_sel_i[0] && wbs_dat_i[2];

    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0: rdata = {28'd0, irq_en, prog_val, prog_sel, rst_req};
            2'd1: rdata = {16'd0, clks_per_bit_o};
            2'd2: rdata = {29'd0, prog_edge, prog_sync, soc_rst_no};
            2'd3: rdata = scratch;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= hit ? rdata : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_req        <= 1'b0;
            prog_sel       <= 1'b0;
            prog_val       <= 1'b0;
            irq_en         <= 1'b0;
            clks_per_bit_o <= CPB_RESET;
            scratch        <= '0;
        end else if (wr) begin
            case (reg_sel)
                2'd0: if (wbs_sel_i[0]) {irq_en, prog_val, prog_sel, rst_req} <= wbs_dat_i[3:0];
                2'd1: begin
                    if (wbs_sel_i[0]) clks_per_bit_o[7:0]  <= wbs_dat_i[7:0];
                    if (wbs_sel_i[1]) clks_per_bit_o[15:8] <= wbs_dat_i[15:8];
                end
                2'd3: for (int b = 0; b < 4; b++)
                    if (wbs_sel_i[b]) scratch[b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prog_meta   <= 1'b0;
            prog_sync   <= 1'b0;
            prog_sync_q <= 1'b0;
            prog_edge   <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            prog_meta   <= prog_pad_i;
            prog_sync   <= prog_meta;
            prog_sync_q <= prog_sync;
            // a new edge beats a simultaneous clear so no event is lost
            prog_edge   <= edge_set | (prog_edge & ~edge_clr);
            irq_o       <= prog_edge & irq_en;
        end
    end

    assign prog_o = prog_sel ? prog_val : prog_sync;

    // rst_req is level-held, so HOLD keeps restarting its count until software clears it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= HOLD;
            count      <= '0;
            soc_rst_no <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    soc_rst_no <= 1'b0;
                    if (rst_req) begin
                        count <= '0;
                    end else if (count == CW'(RST_CYCLES - 1)) begin
                        count      <= '0;
                        state      <= RUN;
                        soc_rst_no <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                RUN: begin
                    count <= '0;
                    if (rst_req) begin
                        state      <= HOLD;
                        soc_rst_no <= 1'b0;
                    end else begin
                        soc_rst_no <= 1'b1;
                    end
                end
                default: begin
                    state      <= HOLD;
                    count      <= '0;
                    soc_rst_no <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_azadi_wb_ctrl.sv
// Directed bench for azadi_wb_ctrl: bus protocol, register map, reset sequencer, prog path.
module tb_azadi_wb_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_dat_i = '0, wbs_adr_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        prog_pad_i = 1'b0;
    logic [15:0] clks_per_bit_o;
    logic        soc_rst_no, prog_o, irq_o;

    int n_tot = 0;
    int n_pass = 0;

    azadi_wb_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .prog_pad_i(prog_pad_i), .clks_per_bit_o(clks_per_bit_o),
        .soc_rst_no(soc_rst_no), .prog_o(prog_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // one transaction: drive at negedge, sample #1 after the hit edge, release at next negedge
    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        @(negedge clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        @(posedge clk_i); #1;
        chk("wr_ack", {31'd0, wbs_ack_o}, 32'd1);
        @(negedge clk_i);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        @(negedge clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = adr;
        @(posedge clk_i); #1;
        chk("rd_ack", {31'd0, wbs_ack_o}, 32'd1);
        dat = wbs_dat_o;
        @(negedge clk_i);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        seen;
        logic [3:0]  ack_pat;

        #1 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ack",  {31'd0, wbs_ack_o},  32'd0);
        chk("rst_dat",  wbs_dat_o,           32'd0);
        chk("rst_soc",  {31'd0, soc_rst_no}, 32'd0);
        chk("rst_prog", {31'd0, prog_o},     32'd0);
        chk("rst_irq",  {31'd0, irq_o},      32'd0);
        chk("rst_cpb",  {16'd0, clks_per_bit_o}, 32'h364);

        // soc_rst_no rises on the 16th edge after release
        @(negedge clk_i); rst_ni = 1'b1;
        repeat (15) @(posedge clk_i);
        #1 chk("seq_15", {31'd0, soc_rst_no}, 32'd0);
        @(posedge clk_i);
        #1 chk("seq_16", {31'd0, soc_rst_no}, 32'd1);

        wb_read(32'h3000_0004, rd);
        chk("cpb_rd", rd, 32'h364);
        @(posedge clk_i); #1;
        chk("ack_1cyc", {31'd0, wbs_ack_o}, 32'd0);
        chk("dat_idle", wbs_dat_o, 32'd0);

        wb_write(32'h3000_0004, 32'h0000_01B2, 4'b0001);
        chk("cpb_out", {16'd0, clks_per_bit_o}, 32'h3B2);
        wb_read(32'h3000_0004, rd);
        chk("cpb_rd2", rd, 32'h3B2);

        wb_write(32'h3000_0000, 32'h1, 4'hF);
        @(posedge clk_i); #1;
        chk("req_low", {31'd0, soc_rst_no}, 32'd0);
        repeat (5) @(posedge clk_i);
        #1 chk("req_hold", {31'd0, soc_rst_no}, 32'd0);
        wb_write(32'h3000_0000, 32'h0, 4'hF);
        repeat (15) @(posedge clk_i);
        #1 chk("rel_15", {31'd0, soc_rst_no}, 32'd0);
        @(posedge clk_i);
        #1 chk("rel_16", {31'd0, soc_rst_no}, 32'd1);

        // masked edge: sticky bit sets, irq stays low
        prog_pad_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1 chk("mask_irq", {31'd0, irq_o}, 32'd0);
        wb_read(32'h3000_0008, rd);
        chk("mask_stat", rd, 32'h7);
        wb_write(32'h3000_0008, 32'h4, 4'h1);
        wb_read(32'h3000_0008, rd);
        chk("w1c_stat", rd, 32'h3);

        wb_write(32'h3000_0000, 32'h8, 4'h1);
        @(negedge clk_i) prog_pad_i = 1'b0;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i) prog_pad_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1 chk("edge_irq", {31'd0, irq_o}, 32'd1);
        wb_read(32'h3000_0008, rd);
        chk("edge_stat", rd, 32'h7);
        wb_write(32'h3000_0008, 32'h4, 4'h1);
        @(posedge clk_i); #1;
        chk("clr_irq", {31'd0, irq_o}, 32'd0);
        wb_read(32'h3000_0008, rd);
        chk("clr_stat", rd, 32'h3);

        wb_write(32'h3000_0000, 32'h6, 4'h1);
        chk("prog_reg1", {31'd0, prog_o}, 32'd1);
        prog_pad_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1 chk("prog_pad0", {31'd0, prog_o}, 32'd1);
        prog_pad_i = 1'b1;
        wb_write(32'h3000_0000, 32'h2, 4'h1);
        repeat (4) @(posedge clk_i);
        #1 chk("prog_reg0", {31'd0, prog_o}, 32'd0);
        wb_read(32'h3000_0000, rd);
        chk("ctrl_rd", rd, 32'h2);

        wb_write(32'h3000_000C, 32'hDEAD_BEEF, 4'hF);
        wb_write(32'h3000_000C, 32'h1234_5678, 4'b0101);
        wb_read(32'h3000_000C, rd);
        chk("scr_bytes", rd, 32'hDE34_BE78);

        // out-of-window write that would alias CTRL if the decode were short
        @(negedge clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h3000_0100; wbs_dat_i = 32'hFFFF_FFFF; wbs_sel_i = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            seen = seen | wbs_ack_o;
        end
        chk("miss_ack", {31'd0, seen}, 32'd0);
        @(negedge clk_i);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
        wb_read(32'h3000_0000, rd);
        chk("miss_ctrl", rd, 32'h2);

        @(negedge clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_000C;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            ack_pat[3-i] = wbs_ack_o;
            chk("held_dat", wbs_dat_o, wbs_ack_o ? 32'hDE34_BE78 : 32'h0);
        end
        chk("held_pat", {28'd0, ack_pat}, 32'hA);
        @(negedge clk_i);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;

        // write under reset is dropped and acks nothing
        @(negedge clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h3000_000C; wbs_dat_i = 32'hA5A5_A5A5; wbs_sel_i = 4'hF;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        chk("rstx_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("rstx_soc", {31'd0, soc_rst_no}, 32'd0);
        @(negedge clk_i);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
        rst_ni = 1'b1;
        wb_read(32'h3000_000C, rd);
        chk("rstx_scr", rd, 32'h0);
        chk("rstx_cpb", {16'd0, clks_per_bit_o}, 32'h364);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
